// File: rtl/upsample_layer_pkg.sv
// Shared CNN map-stream definitions: pixel width, default sizes, row FSM encoding.
// Stream handshake: a pixel moves on a cycle where valid && ready; outputs have no backpressure.
package upsample_layer_pkg;

  localparam int DATA_W       = 16;
  localparam int DEF_MAX_SIZE = 32;
  localparam int DEF_SIZE_W   = 8;

  typedef enum logic {
    ROW_IN  = 1'b0,
    ROW_REP = 1'b1
  } row_state_e;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/upsample_layer_line_buf.sv
// One-row pixel store: registered write, combinational read, no reset (contents are don't-care).
// Zero-latency read; written only while a row is accepted, read only during replay.
module upsample_layer_line_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic              pclk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge pclk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/upsample_layer.sv
// Nearest-neighbour 2x upsampler: each pixel emitted twice, each row replayed once; 1-cycle registered output.
// Throttles upstream via map_ird (one accept per two output cycles, none during replay); no downstream backpressure.
module upsample_layer #(
  parameter int DATA_W   = upsample_layer_pkg::DATA_W,
  parameter int MAX_SIZE = upsample_layer_pkg::DEF_MAX_SIZE,
  parameter int SIZE_W   = upsample_layer_pkg::DEF_SIZE_W
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic [SIZE_W-1:0]        image_size,
  input  logic                     map_iva,
  input  logic signed [DATA_W-1:0] map_in,
  output logic                     map_ird,
  output logic signed [DATA_W-1:0] map_out,
  output logic                     map_ova,
  output logic                     map_oend
);

  import upsample_layer_pkg::*;

  localparam int               AW    = addr_w(MAX_SIZE);
  localparam logic [SIZE_W-1:0] MAX_N = SIZE_W'(MAX_SIZE);
  localparam logic [SIZE_W-1:0] ONE   = SIZE_W'(1);

  row_state_e        state_q, state_d;
  logic [SIZE_W-1:0] col_q, col_d;
  logic [SIZE_W-1:0] row_q, row_d;
  logic [SIZE_W-1:0] n_q, n_d;
  logic              phase_q, phase_d;
  logic [DATA_W-1:0] out_d;
  logic              ova_d, oend_d;

  logic [SIZE_W-1:0] n_sat, n_cur;
  logic              frame_start, accept, last_col, last_row, we;
  logic [DATA_W-1:0] rdata;

  assign n_sat       = (image_size > MAX_N) ? MAX_N : image_size;
  assign frame_start = (state_q == ROW_IN) && (row_q == '0) && (col_q == '0) && !phase_q;
  // While idle at frame start the live size governs readiness, so size 0 holds the input off.
  assign n_cur       = frame_start ? n_sat : n_q;
  assign map_ird     = !rst && (state_q == ROW_IN) && !phase_q && (n_cur != '0);
  assign accept      = map_iva && map_ird;
  assign last_col    = (col_q + ONE) == n_q;
  assign last_row    = (row_q + ONE) == n_q;

  upsample_layer_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_SIZE),
    .AW     (AW)
  ) u_line_buf (
    .pclk  (pclk),
    .we    (we),
    .waddr (col_q[AW-1:0]),
    .wdata (map_in),
    .raddr (col_q[AW-1:0]),
    .rdata (rdata)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    n_d     = n_q;
    phase_d = phase_q;
    out_d   = map_out;
    ova_d   = 1'b0;
    oend_d  = 1'b0;
    we      = 1'b0;
    case (state_q)
      ROW_IN: begin
        if (!phase_q) begin
          if (frame_start) begin
            n_d = n_sat;
          end
          if (accept) begin
            we      = 1'b1;
            out_d   = map_in;
            ova_d   = 1'b1;
            phase_d = 1'b1;
          end
        end else begin
          // Second copy: output register already holds the pixel.
          ova_d   = 1'b1;
          phase_d = 1'b0;
          if (last_col) begin
            col_d   = '0;
            state_d = ROW_REP;
          end else begin
            col_d = col_q + ONE;
          end
        end
      end
      ROW_REP: begin
        out_d   = rdata;
        ova_d   = 1'b1;
        phase_d = ~phase_q;
        if (phase_q) begin
          if (last_col) begin
            col_d   = '0;
            state_d = ROW_IN;
            if (last_row) begin
              row_d  = '0;
              oend_d = 1'b1;
            end else begin
              row_d = row_q + ONE;
            end
          end else begin
            col_d = col_q + ONE;
          end
        end
      end
      default: begin
        state_d = ROW_IN;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q  <= ROW_IN;
      col_q    <= '0;
      row_q    <= '0;
      n_q      <= '0;
      phase_q  <= 1'b0;
      map_out  <= '0;
      map_ova  <= 1'b0;
      map_oend <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      n_q      <= n_d;
      phase_q  <= phase_d;
      map_out  <= out_d;
      map_ova  <= ova_d;
      map_oend <= oend_d;
    end
  end

endmodule
